// File: rtl/serial_pkg.sv
// Shared types, constants and helpers for the serial_tx line transmitter.
// Build option: SERIAL_TX_PARITY_EN adds one even-parity bit to every frame.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   // Clocks from load acceptance to the last stop-bit cycle.
   function automatic int unsigned frame_len(input int unsigned width, input int unsigned div);
`ifdef SERIAL_TX_PARITY_EN
      return (width + 32'd3) * div;
`else
      return (width + 32'd2) * div;
`endif
   endfunction

   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer for serial_tx: counts DIV clocks per serial bit and flags
// the last clock of each bit with a registered one-cycle tick.
module bit_timer
   import serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic c,
   input  logic rn,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] ZERO = CW'(0);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;
   logic          tick_r;

   // Next divider count: restart on frame start, wrap after the last clock of a bit.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear) begin
         cnt_next_s = ZERO;
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_next_s = ZERO;
         end else begin
            cnt_next_s = cnt_r + ONE;
         end
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Counter and tick registers; tick is high while the count sits on the last clock.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         cnt_r  <= ZERO;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         tick_r <= (cnt_next_s == LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial line transmitter: start bit, data LSB first, optional even
// parity (SERIAL_TX_PARITY_EN), stop bit; every bit held for DIV clocks.
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             c,
   input  logic             rn,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             q,
   output logic             qn
);

   localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_ZERO = BW'(0);

   tx_state_t        state_r;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_dn_s;
   logic [BW-1:0]    bit_idx_r;
   logic             q_r;
   logic             qn_r;
   logic             ready_r;
   logic             busy_r;
   logic             done_r;
   logic             accept_s;
   logic             tick_s;
`ifdef SERIAL_TX_PARITY_EN
   logic             parity_r;
`endif

   assign accept_s   = load && ready_r;
   assign shift_dn_s = shift_r >> 1;

   bit_timer #(
      .DIV(DIV)
   ) u_bit_timer (
      .c    (c),
      .rn   (rn),
      .clear(accept_s),
      .en   (busy_r),
      .tick (tick_s)
   );

   // Frame sequencer; every output is registered and set from the state being entered.
   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         state_r   <= IDLE;
         shift_r   <= {WIDTH{1'b0}};
         bit_idx_r <= BIT_ZERO;
         q_r       <= IDLE_LEVEL;
         qn_r      <= ~IDLE_LEVEL;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_r  <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r   <= START;
                  shift_r   <= d;
                  bit_idx_r <= BIT_ZERO;
`ifdef SERIAL_TX_PARITY_EN
                  parity_r  <= even_parity(32'(d));
`endif
                  q_r       <= 1'b0;
                  qn_r      <= 1'b1;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
               end
            end
            START: begin
               if (tick_s) begin
                  state_r <= DATA;
                  q_r     <= shift_r[0];
                  qn_r    <= ~shift_r[0];
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                     state_r <= PARITY;
                     q_r     <= parity_r;
                     qn_r    <= ~parity_r;
`else
                     state_r <= STOP;
                     q_r     <= IDLE_LEVEL;
                     qn_r    <= ~IDLE_LEVEL;
`endif
                  end else begin
                     bit_idx_r <= bit_idx_r + BIT_ONE;
                     shift_r   <= shift_dn_s;
                     q_r       <= shift_dn_s[0];
                     qn_r      <= ~shift_dn_s[0];
                  end
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (tick_s) begin
                  state_r <= STOP;
                  q_r     <= IDLE_LEVEL;
                  qn_r    <= ~IDLE_LEVEL;
               end
            end
`endif
            STOP: begin
               // The line already sits at the idle level, so only the handshake changes.
               if (tick_s) begin
                  state_r <= IDLE;
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               q_r     <= IDLE_LEVEL;
               qn_r    <= ~IDLE_LEVEL;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign q     = q_r;
   assign qn    = qn_r;

endmodule
